// File: rtl/audio_pkg.sv
// Shared constants, FSM encoding and frame builder for the audio SPI blocks.
// The LTC2624 frame is 32 bits: pad byte, command, address, sample, pad nibble.
package audio_pkg;

    localparam logic [3:0] LTC2624_CMD_WRITE_UPDATE = 4'b0011;
    localparam logic [3:0] LTC2624_ADDR_ALL         = 4'b1111;
    localparam int         LTC2624_FRAME_W          = 32;
    localparam int         SAMPLE_W                 = 12;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_GAP   = 2'd2
    } tx_state_e;

    function automatic logic [LTC2624_FRAME_W-1:0] ltc2624_frame(
        input logic [3:0]          cmd,
        input logic [3:0]          addr,
        input logic [SAMPLE_W-1:0] sample
    );
        return {8'h00, cmd, addr, sample, 4'h0};
    endfunction

endpackage

// File: rtl/spi_clk_div.sv
// SPI clock divider: while enabled, emits one strobe every CLK_DIV cycles,
// alternating between rise and fall so the owner can drive a low-first sck.
module spi_clk_div #(
    parameter int unsigned CLK_DIV = 2
) (
    input  logic clock,
    input  logic reset,
    input  logic en_i,
    output logic rise_o,
    output logic fall_o
);

    localparam int unsigned     CNT_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);

    logic [CNT_W-1:0] cnt_q;
    logic             phase_q;
    logic             tick;

    assign tick   = en_i && (cnt_q == CNT_LAST);
    assign rise_o = tick && !phase_q;
    assign fall_o = tick &&  phase_q;

    // NOTE: non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock) begin
        if (reset || !en_i) begin
            cnt_q   <= '0;
            phase_q <= 1'b0;
        end else if (tick) begin
            cnt_q   <= '0;
            phase_q <= !phase_q;
        end else begin
            cnt_q   <= cnt_q + 1'b1;
        end
    end

endmodule

// File: rtl/dac_spi_tx.sv
// Serialises one 12-bit sample per handshake into an LTC2624 write-and-update
// frame. All SPI pins and handshake outputs come straight from flops.
module dac_spi_tx
    import audio_pkg::*;
#(
    parameter int unsigned CLK_DIV  = 2,
    parameter logic [3:0]  DAC_CMD  = LTC2624_CMD_WRITE_UPDATE,
    parameter logic [3:0]  DAC_ADDR = LTC2624_ADDR_ALL,
    parameter int unsigned CS_GAP   = 4
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [SAMPLE_W-1:0] sample_data,
    input  logic                sample_valid,
    output logic                sample_ready,
    output logic                busy,
    output logic                sck,
    output logic                mosi,
    output logic                daccs,
    output logic                dacclr
);

    localparam int unsigned      GAP_W    = (CS_GAP > 1) ? $clog2(CS_GAP) : 1;
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(CS_GAP - 1);

    tx_state_e                  state_q;
    logic [LTC2624_FRAME_W-1:0] frame_q;
    logic [LTC2624_FRAME_W-1:0] frame_d;
    logic [4:0]                 bit_idx_q;
    logic [GAP_W-1:0]           gap_cnt_q;
    logic                       sample_ready_q;
    logic                       busy_q;
    logic                       sck_q;
    logic                       mosi_q;
    logic                       daccs_q;
    logic                       dacclr_q;
    logic                       sck_rise;
    logic                       sck_fall;
    logic                       accept;

    assign frame_d = ltc2624_frame(DAC_CMD, DAC_ADDR, sample_data);
    assign accept  = sample_valid && sample_ready_q;

    spi_clk_div #(
        .CLK_DIV (CLK_DIV)
    ) u_clk_div (
        .clock  (clock),
        .reset  (reset),
        .en_i   (state_q == ST_SHIFT),
        .rise_o (sck_rise),
        .fall_o (sck_fall)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q        <= ST_IDLE;
            frame_q        <= '0;
            bit_idx_q      <= '0;
            gap_cnt_q      <= '0;
            sample_ready_q <= 1'b0;
            busy_q         <= 1'b0;
            sck_q          <= 1'b0;
            mosi_q         <= 1'b0;
            daccs_q        <= 1'b1;
            dacclr_q       <= 1'b0;
        end else begin
            dacclr_q <= 1'b1;
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        state_q        <= ST_SHIFT;
                        frame_q        <= frame_d;
                        mosi_q         <= frame_d[LTC2624_FRAME_W-1];
                        bit_idx_q      <= 5'd31;
                        daccs_q        <= 1'b0;
                        sample_ready_q <= 1'b0;
                        busy_q         <= 1'b1;
                    end else begin
                        sample_ready_q <= 1'b1;
                        busy_q         <= 1'b0;
                    end
                end
                ST_SHIFT: begin
                    if (sck_rise) begin
                        sck_q <= 1'b1;
                    end
                    // mosi only moves on the falling strobe, so it is stable while sck is high
                    if (sck_fall) begin
                        sck_q <= 1'b0;
                        if (bit_idx_q == 5'd0) begin
                            state_q   <= ST_GAP;
                            daccs_q   <= 1'b1;
                            mosi_q    <= 1'b0;
                            gap_cnt_q <= '0;
                        end else begin
                            bit_idx_q <= bit_idx_q - 5'd1;
                            frame_q   <= frame_q << 1;
                            mosi_q    <= frame_q[LTC2624_FRAME_W-2];
                        end
                    end
                end
                ST_GAP: begin
                    if (gap_cnt_q == GAP_LAST) begin
                        state_q        <= ST_IDLE;
                        sample_ready_q <= 1'b1;
                        busy_q         <= 1'b0;
                    end else begin
                        gap_cnt_q <= gap_cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    daccs_q <= 1'b1;
                    sck_q   <= 1'b0;
                end
            endcase
        end
    end

    assign sample_ready = sample_ready_q;
    assign busy         = busy_q;
    assign sck          = sck_q;
    assign mosi         = mosi_q;
    assign daccs        = daccs_q;
    assign dacclr       = dacclr_q;

endmodule

// File: tb/tb_dac_spi_tx.sv
// Bench for dac_spi_tx: two instances (CLK_DIV=1 and CLK_DIV=3) observed by an
// SPI slave-style monitor and compared against frames built from the LTC2624 rules.
module tb_dac_spi_tx;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic [1:0]  reset;
    logic [11:0] sdata [2];
    logic [1:0]  valid;
    wire  [1:0]  ready, busy, sck, mosi, daccs, dacclr;

    int checks   = 0;
    int failures = 0;
    int unsigned cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    dac_spi_tx #(.CLK_DIV(1), .CS_GAP(4)) dut_div1 (
        .clock(clock), .reset(reset[0]), .sample_data(sdata[0]), .sample_valid(valid[0]),
        .sample_ready(ready[0]), .busy(busy[0]), .sck(sck[0]), .mosi(mosi[0]),
        .daccs(daccs[0]), .dacclr(dacclr[0])
    );

    dac_spi_tx #(.CLK_DIV(3), .CS_GAP(4)) dut_div3 (
        .clock(clock), .reset(reset[1]), .sample_data(sdata[1]), .sample_valid(valid[1]),
        .sample_ready(ready[1]), .busy(busy[1]), .sck(sck[1]), .mosi(mosi[1]),
        .daccs(daccs[1]), .dacclr(dacclr[1])
    );

    function automatic int div_of(input int g);
        return (g == 0) ? 1 : 3;
    endfunction

    // Reference: pad byte, command 0011, address 1111, sample, pad nibble.
    function automatic logic [31:0] model_frame(input logic [11:0] s);
        return 32'h003F_0000 + (32'(s) * 32'd16);
    endfunction

    function automatic int unsigned model_interval(input int g);
        return 1 + 64 * div_of(g) + 4;
    endfunction

    // Monitor state: what a slave sampling on sck rise would see.
    logic [1:0]  p_sck, p_daccs, p_mosi;
    logic [31:0] word [2];
    int          bits [2], low [2], run [2], run_err [2], tog_err [2];
    logic [31:0] last_frame [2];
    int          last_bits [2], last_low [2], last_run_err [2], last_tog_err [2];
    int          frame_cnt [2], acc_cnt [2];
    int unsigned acc_cyc [2], prev_acc_cyc [2];

    always @(negedge clock) begin
        for (int g = 0; g < 2; g++) begin
            if (valid[g] && ready[g] && !reset[g]) begin
                prev_acc_cyc[g] = acc_cyc[g];
                acc_cyc[g]      = cyc;
                acc_cnt[g]      = acc_cnt[g] + 1;
            end
            if (daccs[g] === 1'b0) begin
                if (p_daccs[g]) begin
                    word[g] = '0; bits[g] = 0; low[g] = 1; run[g] = 1;
                    run_err[g] = 0; tog_err[g] = 0;
                end else begin
                    low[g] = low[g] + 1;
                    if (sck[g] == p_sck[g]) begin
                        run[g] = run[g] + 1;
                    end else begin
                        if (run[g] != div_of(g)) run_err[g] = run_err[g] + 1;
                        run[g] = 1;
                    end
                    if (sck[g] && p_sck[g] && (mosi[g] != p_mosi[g])) tog_err[g] = tog_err[g] + 1;
                end
                if (sck[g] && !p_sck[g]) begin
                    word[g] = {word[g][30:0], mosi[g]};
                    bits[g] = bits[g] + 1;
                end
            end else if (!p_daccs[g]) begin
                if (run[g] != div_of(g)) run_err[g] = run_err[g] + 1;
                last_frame[g]   = word[g];
                last_bits[g]    = bits[g];
                last_low[g]     = low[g];
                last_run_err[g] = run_err[g];
                last_tog_err[g] = tog_err[g];
                frame_cnt[g]    = frame_cnt[g] + 1;
            end
            p_sck[g]   = sck[g];
            p_daccs[g] = (daccs[g] !== 1'b0);
            p_mosi[g]  = mosi[g];
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic send(input int g, input logic [11:0] s);
        int t = 0;
        sdata[g] = s;
        valid[g] = 1'b1;
        while (ready[g] !== 1'b1 && t < 1000) begin step(); t++; end
        checks++;
        if (ready[g] !== 1'b1) begin
            failures++;
            $display("FAIL send_ready dut%0d: sample_ready=%b required 1", g, ready[g]);
        end
        step();
        valid[g] = 1'b0;
    endtask

    task automatic wait_frame(input int g, input int n0);
        int t = 0;
        while (frame_cnt[g] <= n0 && t < 1000) begin step(); t++; end
        checks++;
        if (frame_cnt[g] <= n0) begin
            failures++;
            $display("FAIL frame_timeout dut%0d: no frame end within 1000 cycles", g);
        end
    endtask

    task automatic test_reset();
        reset = 2'b11; valid = 2'b00; sdata[0] = '0; sdata[1] = '0;
        repeat (3) step();
        for (int g = 0; g < 2; g++) begin
            checks++;
            if ({ready[g], busy[g], sck[g], mosi[g], daccs[g], dacclr[g]} !== 6'b000010) begin
                failures++;
                $display("FAIL reset_values dut%0d: ready,busy,sck,mosi,daccs,dacclr=%b%b%b%b%b%b required 000010",
                         g, ready[g], busy[g], sck[g], mosi[g], daccs[g], dacclr[g]);
            end
        end
        reset = 2'b00;
        step();
        for (int g = 0; g < 2; g++) begin
            checks++;
            if ({ready[g], dacclr[g], daccs[g]} !== 3'b111) begin
                failures++;
                $display("FAIL reset_release dut%0d: ready,dacclr,daccs=%b%b%b required 111",
                         g, ready[g], dacclr[g], daccs[g]);
            end
        end
    endtask

    task automatic test_idle();
        for (int i = 0; i < 1000; i++) begin
            step();
            for (int g = 0; g < 2; g++) begin
                checks++;
                if ({sck[g], daccs[g], mosi[g], dacclr[g], ready[g], busy[g]} !== 6'b010110) begin
                    failures++;
                    $display("FAIL idle_quiet dut%0d cycle %0d: sck,daccs,mosi,dacclr,ready,busy=%b%b%b%b%b%b required 010110",
                             g, i, sck[g], daccs[g], mosi[g], dacclr[g], ready[g], busy[g]);
                end
            end
        end
    endtask

    task automatic test_single_frame(input int g, input logic [11:0] s);
        int n0 = frame_cnt[g];
        send(g, s);
        checks++;
        if ({busy[g], ready[g], daccs[g], mosi[g]} !== {3'b100, model_frame(s)[31]}) begin
            failures++;
            $display("FAIL accept_edge dut%0d: busy,ready,daccs,mosi=%b%b%b%b required 100%b",
                     g, busy[g], ready[g], daccs[g], mosi[g], model_frame(s)[31]);
        end
        wait_frame(g, n0);
        checks++;
        if (last_frame[g] !== model_frame(s)) begin
            failures++;
            $display("FAIL single_word dut%0d: got %h required %h", g, last_frame[g], model_frame(s));
        end
        checks++;
        if (last_bits[g] != 32 || last_low[g] != 64 * div_of(g)) begin
            failures++;
            $display("FAIL single_timing dut%0d: rises=%0d cs_low=%0d required 32 and %0d",
                     g, last_bits[g], last_low[g], 64 * div_of(g));
        end
        checks++;
        if (last_run_err[g] != 0 || last_tog_err[g] != 0) begin
            failures++;
            $display("FAIL single_sck_shape dut%0d: bad sck phases=%0d mosi toggles while high=%0d required 0 and 0",
                     g, last_run_err[g], last_tog_err[g]);
        end
    endtask

    task automatic test_back_to_back(input int g, input logic [11:0] s0, input logic [11:0] s1,
                                     input int change_at);
        logic [31:0] got [2];
        int          n0 = frame_cnt[g];
        int          a0 = acc_cnt[g];
        int          seen = 0;
        int          t = 0;
        int unsigned gap_cyc = 0;
        sdata[g] = s0;
        valid[g] = 1'b1;
        while (acc_cnt[g] == a0 && t < 1000) begin step(); t++; end
        repeat (change_at) step();
        sdata[g] = s1;
        t = 0;
        while (seen < 2 && t < 1500) begin
            step(); t++;
            if (acc_cnt[g] >= a0 + 2 && valid[g]) begin
                valid[g] = 1'b0;
                gap_cyc  = acc_cyc[g] - prev_acc_cyc[g];
            end
            if (frame_cnt[g] > n0 + seen) begin
                got[seen] = last_frame[g];
                seen++;
            end
        end
        valid[g] = 1'b0;
        checks++;
        if (seen != 2) begin
            failures++;
            $display("FAIL b2b_count dut%0d: frames=%0d required 2", g, seen);
        end
        checks++;
        if (got[0] !== model_frame(s0)) begin
            failures++;
            $display("FAIL b2b_first dut%0d: got %h required %h", g, got[0], model_frame(s0));
        end
        checks++;
        if (got[1] !== model_frame(s1)) begin
            failures++;
            $display("FAIL b2b_second dut%0d: got %h required %h", g, got[1], model_frame(s1));
        end
        checks++;
        if (gap_cyc != model_interval(g)) begin
            failures++;
            $display("FAIL b2b_interval dut%0d: accept spacing %0d required %0d", g, gap_cyc, model_interval(g));
        end
    endtask

    task automatic test_mid_reset(input int g);
        int t = 0;
        int n0;
        send(g, 12'($urandom));
        step();
        while (bits[g] < 16 && t < 1000) begin step(); t++; end
        reset[g] = 1'b1;
        step();
        checks++;
        if ({daccs[g], sck[g], dacclr[g], busy[g], ready[g]} !== 5'b10000) begin
            failures++;
            $display("FAIL midreset_force dut%0d: daccs,sck,dacclr,busy,ready=%b%b%b%b%b required 10000",
                     g, daccs[g], sck[g], dacclr[g], busy[g], ready[g]);
        end
        repeat (2) step();
        reset[g] = 1'b0;
        repeat (3) step();
        checks++;
        if ({daccs[g], sck[g], busy[g]} !== 3'b100) begin
            failures++;
            $display("FAIL midreset_abandon dut%0d: daccs,sck,busy=%b%b%b required 100",
                     g, daccs[g], sck[g], busy[g]);
        end
        n0 = frame_cnt[g];
        send(g, 12'h555);
        wait_frame(g, n0);
        checks++;
        if (last_frame[g] !== 32'h003F5550 || last_bits[g] != 32) begin
            failures++;
            $display("FAIL midreset_clean dut%0d: got %h with %0d rises required 003f5550 with 32",
                     g, last_frame[g], last_bits[g]);
        end
    endtask

    task automatic test_random(input int g, input int n);
        logic [11:0] s;
        int          n0;
        for (int i = 0; i < n; i++) begin
            s  = 12'($urandom);
            n0 = frame_cnt[g];
            repeat ($urandom_range(0, 5)) step();
            send(g, s);
            sdata[g] = 12'($urandom);
            wait_frame(g, n0);
            checks++;
            if (last_frame[g] !== model_frame(s) || last_bits[g] != 32 || last_low[g] != 64 * div_of(g)
                || last_run_err[g] != 0 || last_tog_err[g] != 0) begin
                failures++;
                $display("FAIL random_frame dut%0d #%0d: word=%h rises=%0d cs_low=%0d phase_errs=%0d toggles=%0d required word=%h rises=32 cs_low=%0d",
                         g, i, last_frame[g], last_bits[g], last_low[g], last_run_err[g], last_tog_err[g],
                         model_frame(s), 64 * div_of(g));
            end
        end
    endtask

    initial begin
        p_sck = 2'b00; p_daccs = 2'b11; p_mosi = 2'b00;
        test_reset();
        test_idle();
        test_single_frame(0, 12'hABC);
        test_single_frame(1, 12'hABC);
        test_back_to_back(0, 12'h000, 12'hFFF, 0);
        test_back_to_back(1, 12'h000, 12'hFFF, 0);
        test_back_to_back(0, 12'hABC, 12'h123, 20);
        test_back_to_back(1, 12'hABC, 12'h123, 60);
        test_mid_reset(0);
        test_mid_reset(1);
        test_random(0, 8);
        test_random(1, 8);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #900_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
